// File: rtl/alu_control_seq_if.sv
// ALU control bundle: decode inputs, mul/div operands, control and HI/LO outputs.
// Master drives the instruction fields and operands; slave returns control/status.
// Plain wires only, no storage; width parameters must match the attached block.
interface alu_control_seq_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
);
    logic [1:0]        aluop;
    logic [5:0]        funct;
    logic [5:0]        opcode;
    logic              valid;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              illegal;
    logic              stall;
    logic              done;
    logic              div_zero;
    logic [WIDTH-1:0]  hilo_out;

    modport master (
        output aluop, funct, opcode, valid, op_a, op_b,
        input  alu_ctrl, illegal, stall, done, div_zero, hilo_out
    );

    modport slave (
        input  aluop, funct, opcode, valid, op_a, op_b,
        output alu_ctrl, illegal, stall, done, div_zero, hilo_out
    );
endinterface

// File: rtl/alu_control_seq.sv
// ALU control decode plus iterative mul/div sequencer owning HI/LO (signed ops under ALU_SIGNED_MULDIV_EN).
// Decode is combinational; MULT/DIV take WIDTH+1 stall cycles, divide-by-zero takes 1, done pulses after.
// stall holds the pipeline while busy; issues arriving while busy are ignored.
module alu_control_seq #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    alu_control_seq_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    localparam logic [CTRL_W-1:0] C_AND  = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] C_OR   = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] C_ADD  = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] C_XOR  = CTRL_W'(4'b0011);
    localparam logic [CTRL_W-1:0] C_NOR  = CTRL_W'(4'b0100);
    localparam logic [CTRL_W-1:0] C_SUB  = CTRL_W'(4'b0110);
    localparam logic [CTRL_W-1:0] C_SLT  = CTRL_W'(4'b0111);
    localparam logic [CTRL_W-1:0] C_SLTU = CTRL_W'(4'b1000);
    localparam logic [CTRL_W-1:0] C_SLL  = CTRL_W'(4'b1001);
    localparam logic [CTRL_W-1:0] C_SRL  = CTRL_W'(4'b1010);
    localparam logic [CTRL_W-1:0] C_SRA  = CTRL_W'(4'b1011);
    localparam logic [CNT_W-1:0]  LAST   = CNT_W'(WIDTH - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  p_q, p_d;      // {HI-side, LO-side}: product or {remainder, quotient}
    logic [WIDTH-1:0]    b_q, b_d;      // multiplicand / divisor magnitude
    logic [WIDTH-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic                dz_q, dz_d;
    logic                div_q, div_d;  // operation in flight is a divide
    logic                zero_q, zero_d; // divide by zero, result preloaded
    logic                done_q;
`ifdef ALU_SIGNED_MULDIV_EN
    logic                qneg_q, qneg_d; // negate product / quotient in FIN
    logic                rneg_q, rneg_d; // negate remainder in FIN
`endif

    logic [CTRL_W-1:0]   ctrl;
    logic                illegal;
    logic                is_mul, is_div, is_signed, issue;
    logic [WIDTH-1:0]    mag_a, mag_b;
    logic [WIDTH:0]      msum, trial;
    logic [2*WIDTH-1:0]  mul_next, div_next;
    logic [WIDTH-1:0]    rem_new;
    logic [WIDTH-1:0]    fin_hi, fin_lo;

    // Instruction field decode to ALU operation code; every path assigns both outputs.
    always_comb begin
        ctrl    = C_ADD;
        illegal = 1'b0;
        case (bus.aluop)
            2'b00: ctrl = C_ADD;
            2'b01: ctrl = C_SUB;
            2'b10: begin
                case (bus.funct)
                    6'b100000, 6'b100001: ctrl = C_ADD;
                    6'b100010, 6'b100011: ctrl = C_SUB;
                    6'b100100: ctrl = C_AND;
                    6'b100101: ctrl = C_OR;
                    6'b100110: ctrl = C_XOR;
                    6'b100111: ctrl = C_NOR;
                    6'b101010: ctrl = C_SLT;
                    6'b101011: ctrl = C_SLTU;
                    6'b000000: ctrl = C_SLL;
                    6'b000010: ctrl = C_SRL;
                    6'b000011: ctrl = C_SRA;
                    6'b011001, 6'b011011, 6'b010000, 6'b010010: ctrl = C_ADD;
`ifdef ALU_SIGNED_MULDIV_EN
                    6'b011000, 6'b011010: ctrl = C_ADD;
`endif
                    default: begin
                        ctrl    = C_ADD;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                case (bus.opcode)
                    6'b001000, 6'b001001: ctrl = C_ADD;
                    6'b001100: ctrl = C_AND;
                    6'b001101: ctrl = C_OR;
                    6'b001110: ctrl = C_XOR;
                    6'b001010: ctrl = C_SLT;
                    6'b001011: ctrl = C_SLTU;
                    default: begin
                        ctrl    = C_ADD;
                        illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Issue qualification and operand magnitudes loaded on the issue edge.
    always_comb begin
`ifdef ALU_SIGNED_MULDIV_EN
        is_signed = (bus.funct == 6'b011000) || (bus.funct == 6'b011010);
        is_mul    = (bus.funct == 6'b011001) || (bus.funct == 6'b011000);
        is_div    = (bus.funct == 6'b011011) || (bus.funct == 6'b011010);
        mag_a     = (is_signed && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
        mag_b     = (is_signed && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
`else
        is_signed = 1'b0;
        is_mul    = (bus.funct == 6'b011001);
        is_div    = (bus.funct == 6'b011011);
        mag_a     = bus.op_a;
        mag_b     = bus.op_b;
`endif
        issue = (state_q == IDLE) && bus.valid && (bus.aluop == 2'b10) && (is_mul || is_div);
    end

    // One shift-add step and one restoring-divide step over the shared p register.
    always_comb begin
        msum     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        mul_next = {msum, p_q[WIDTH-1:1]};
        trial    = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]} - {1'b0, b_q};
        rem_new  = trial[WIDTH] ? {p_q[2*WIDTH-2:WIDTH], p_q[WIDTH-1]} : trial[WIDTH-1:0];
        div_next = {rem_new, p_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    // Final HI/LO values, with sign correction for signed operations.
    always_comb begin
        fin_hi = p_q[2*WIDTH-1:WIDTH];
        fin_lo = p_q[WIDTH-1:0];
`ifdef ALU_SIGNED_MULDIV_EN
        if (!div_q && qneg_q) begin
            {fin_hi, fin_lo} = -p_q;
        end
        if (div_q && rneg_q) fin_hi = -p_q[2*WIDTH-1:WIDTH];
        if (div_q && qneg_q) fin_lo = -p_q[WIDTH-1:0];
`endif
    end

    // Sequencer next state and datapath next values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        div_d   = div_q;
        zero_d  = zero_q;
`ifdef ALU_SIGNED_MULDIV_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            IDLE: begin
                if (issue) begin
                    cnt_d  = '0;
                    p_d    = {{WIDTH{1'b0}}, mag_a};
                    b_d    = mag_b;
                    div_d  = is_div;
                    zero_d = 1'b0;
`ifdef ALU_SIGNED_MULDIV_EN
                    qneg_d = is_signed && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                    rneg_d = is_signed && bus.op_a[WIDTH-1];
`endif
                    if (is_div && (bus.op_b == '0)) begin
                        // Result is preloaded raw: HI=op_a, LO=all ones, no sign fix.
                        p_d     = {bus.op_a, {WIDTH{1'b1}}};
                        zero_d  = 1'b1;
                        dz_d    = 1'b1;
`ifdef ALU_SIGNED_MULDIV_EN
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
`endif
                        state_d = FIN;
                    end else begin
                        state_d = is_div ? DIV : MUL;
                    end
                end
            end
            MUL: begin
                p_d   = mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) state_d = FIN;
            end
            DIV: begin
                p_d   = div_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) state_d = FIN;
            end
            default: begin
                hi_d = fin_hi;
                lo_d = fin_lo;
                if (div_q && !zero_q) dz_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath and status registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            p_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            dz_q   <= 1'b0;
            div_q  <= 1'b0;
            zero_q <= 1'b0;
            done_q <= 1'b0;
`ifdef ALU_SIGNED_MULDIV_EN
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            p_q    <= p_d;
            b_q    <= b_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            dz_q   <= dz_d;
            div_q  <= div_d;
            zero_q <= zero_d;
            done_q <= (state_q == FIN);
`ifdef ALU_SIGNED_MULDIV_EN
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
`endif
        end
    end

    assign bus.alu_ctrl = ctrl;
    assign bus.illegal  = illegal;
    assign bus.stall    = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hilo_out = (bus.funct == 6'b010000) ? hi_q : lo_q;

endmodule

// File: tb/tb_alu_control_seq.sv
module tb_alu_control_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_control_seq_if #(.WIDTH(32), .CTRL_W(4)) bus ();
    alu_control_seq #(.WIDTH(32), .CTRL_W(4), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    alu_control_seq_if #(.WIDTH(8), .CTRL_W(4)) bus8 ();
    alu_control_seq #(.WIDTH(8), .CTRL_W(4), .CNT_W(4)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8.slave)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic        dz_m  = 1'b0;
    logic [31:0] hi_m  = '0;
    logic [31:0] lo_m  = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one mul/div, track stall length, then compare against the scoreboard entry.
    task automatic issue(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stall);
        exp_t               e;
        exp_t               got;
        logic [63:0]        p;
        logic signed [63:0] sp;
        logic signed [31:0] sa, sbv;
        int                 n;
        e.dz = dz_m;
        e.hi = hi_m;
        e.lo = lo_m;
        sa   = a;
        sbv  = b;
        case (f)
            6'b011001: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            6'b011000: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                e.hi = sp[63:32]; e.lo = sp[31:0];
            end
            6'b011011: begin
                if (b == 0) begin e.hi = a; e.lo = '1; e.dz = 1'b1; end
                else begin e.hi = a % b; e.lo = a / b; e.dz = 1'b0; end
            end
            default: begin
                if (b == 0) begin e.hi = a; e.lo = '1; e.dz = 1'b1; end
                else begin e.hi = sa % sbv; e.lo = sa / sbv; e.dz = 1'b0; end
            end
        endcase
        dz_m = e.dz; hi_m = e.hi; lo_m = e.lo;
        sb.push_back(e);

        @(negedge clk);
        bus.aluop = 2'b10; bus.funct = f; bus.op_a = a; bus.op_b = b; bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0; bus.funct = 6'b010010;
        n = 0;
        while (bus.stall === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_stall_cycles"}, 64'(n), 64'(exp_stall));
        check({tag, "_done"}, 64'(bus.done), 64'd1);
        got = sb.pop_front();
        #1;
        check({tag, "_lo"}, 64'(bus.hilo_out), 64'(got.lo));
        bus.funct = 6'b010000;
        #1;
        check({tag, "_hi"}, 64'(bus.hilo_out), 64'(got.hi));
        check({tag, "_div_zero"}, 64'(bus.div_zero), 64'(got.dz));
        @(negedge clk);
        check({tag, "_done_drop"}, 64'(bus.done), 64'd0);
    endtask

    logic [5:0] f_tab [17] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                               6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                               6'b000000, 6'b000010, 6'b000011, 6'b011001, 6'b011011,
                               6'b010000, 6'b010010};
    logic [3:0] c_tab [17] = '{4'h2, 4'h2, 4'h6, 4'h6, 4'h0, 4'h1, 4'h3, 4'h4, 4'h7, 4'h8,
                               4'h9, 4'hA, 4'hB, 4'h2, 4'h2, 4'h2, 4'h2};

    initial begin
        int n;
        int pulses;
        rst = 1'b1;
        bus.aluop = 2'b00; bus.funct = 6'b0; bus.opcode = 6'b0; bus.valid = 1'b0;
        bus.op_a = '0; bus.op_b = '0;
        bus8.aluop = 2'b00; bus8.funct = 6'b0; bus8.opcode = 6'b0; bus8.valid = 1'b0;
        bus8.op_a = '0; bus8.op_b = '0;
        repeat (2) @(negedge clk);
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_div_zero", 64'(bus.div_zero), 64'd0);
        check("rst_lo", 64'(bus.hilo_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Decode sweep.
        bus.aluop = 2'b00; #1;
        check("dec_aluop00", 64'({bus.illegal, bus.alu_ctrl}), 64'h02);
        bus.aluop = 2'b01; #1;
        check("dec_aluop01", 64'({bus.illegal, bus.alu_ctrl}), 64'h06);
        bus.aluop = 2'b10;
        for (int i = 0; i < 17; i++) begin
            bus.funct = f_tab[i]; #1;
            check($sformatf("dec_funct_%b", f_tab[i]), 64'({bus.illegal, bus.alu_ctrl}),
                  64'({1'b0, c_tab[i]}));
        end
        bus.funct = 6'b111111; #1;
        check("dec_funct_illegal", 64'({bus.illegal, bus.alu_ctrl}), 64'h12);
        bus.aluop = 2'b11; bus.opcode = 6'b001101; #1;
        check("dec_ori", 64'({bus.illegal, bus.alu_ctrl}), 64'h01);
        bus.opcode = 6'b001010; #1;
        check("dec_slti", 64'({bus.illegal, bus.alu_ctrl}), 64'h07);
        bus.opcode = 6'b111111; #1;
        check("dec_opcode_illegal", 64'({bus.illegal, bus.alu_ctrl}), 64'h12);

        // Multiply / divide through the scoreboard.
        issue("multu", 6'b011001, 32'hFFFF_FFFF, 32'h0000_0002, 33);
        issue("divu", 6'b011011, 32'd100, 32'd7, 33);
        issue("divu_zero", 6'b011011, 32'd5, 32'd0, 1);
        issue("multu_big", 6'b011001, 32'h1234_5678, 32'h9ABC_DEF1, 33);

        // MULTU without valid: no stall, HI/LO untouched.
        @(negedge clk);
        bus.aluop = 2'b10; bus.funct = 6'b011001; bus.op_a = 32'd3; bus.op_b = 32'd3;
        bus.valid = 1'b0;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.stall !== 1'b0) n++;
        end
        check("novalid_stall", 64'(n), 64'd0);
        bus.funct = 6'b010010; #1;
        check("novalid_lo", 64'(bus.hilo_out), 64'(lo_m));

        // Reset in the middle of a MULTU.
        @(negedge clk);
        bus.funct = 6'b011001; bus.op_a = 32'd9; bus.op_b = 32'd9; bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0; bus.funct = 6'b010010;
        repeat (9) @(negedge clk);
        check("midop_busy", 64'(bus.stall), 64'd1);
        rst = 1'b1; #1;
        check("midrst_stall", 64'(bus.stall), 64'd0);
        check("midrst_lo", 64'(bus.hilo_out), 64'd0);
        check("midrst_div_zero", 64'(bus.div_zero), 64'd0);
        bus.funct = 6'b010000; #1;
        check("midrst_hi", 64'(bus.hilo_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dz_m = 1'b0; hi_m = '0; lo_m = '0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.stall === 1'b1) pulses++;
        end
        check("midrst_no_done", 64'(pulses), 64'd0);

`ifdef ALU_SIGNED_MULDIV_EN
        bus.aluop = 2'b10; bus.funct = 6'b011000; #1;
        check("dec_mult_legal", 64'({bus.illegal, bus.alu_ctrl}), 64'h02);
        issue("div_signed", 6'b011010, 32'hFFFF_FFF9, 32'd2, 33);
        issue("mult_signed", 6'b011000, 32'hFFFF_FFFD, 32'd4, 33);
        issue("div_signed_zero", 6'b011010, 32'hFFFF_FFF9, 32'd0, 1);
`else
        @(negedge clk);
        bus.aluop = 2'b10; bus.funct = 6'b011000; bus.op_a = 32'd3; bus.op_b = 32'd4;
        bus.valid = 1'b1; #1;
        check("dec_mult_illegal", 64'({bus.illegal, bus.alu_ctrl}), 64'h12);
        @(negedge clk);
        bus.valid = 1'b0;
        check("mult_no_stall", 64'(bus.stall), 64'd0);
        bus.funct = 6'b010010;
`endif

        // WIDTH=8 instance: MULTU 0xFF*0xFF.
        @(negedge clk);
        bus8.aluop = 2'b10; bus8.funct = 6'b011001; bus8.op_a = 8'hFF; bus8.op_b = 8'hFF;
        bus8.valid = 1'b1;
        @(negedge clk);
        bus8.valid = 1'b0; bus8.funct = 6'b010010;
        n = 0;
        while (bus8.stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("w8_stall_cycles", 64'(n), 64'd9);
        check("w8_done", 64'(bus8.done), 64'd1);
        #1;
        check("w8_lo", 64'(bus8.hilo_out), 64'h01);
        bus8.funct = 6'b010000; #1;
        check("w8_hi", 64'(bus8.hilo_out), 64'hFE);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
